// File: rtl/e203_exu_longp_sched_pkg.sv
// -----------------------------------------------------------------------------
// e203_exu_longp_sched_pkg
// Shared widths for the long-pipe write-back scheduler. The values track the
// core-wide defaults (FLEN, RFIDX_WIDTH, THREADS_NUM) and a helper that sizes
// a thread index, so a single-thread build still gets a 1-bit index.
// -----------------------------------------------------------------------------
package e203_exu_longp_sched_pkg;

   localparam int E203_FLEN        = 32;
   localparam int E203_RFIDX_WIDTH = 5;
   localparam int E203_THREADS_NUM = 2;
   localparam int E203_FLAG_W      = 5;

   // width of a thread index; never zero
   function automatic int rr_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/e203_exu_longp_sched_arb.sv
// -----------------------------------------------------------------------------
// e203_rr_arb
// THREADS-wide round-robin arbiter with a grant lock.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector
//   lock       : when high, repeat last cycle's grant instead of re-arbitrating
//   acc        : the current grant was accepted; advances the priority pointer
//   grant      : one-hot grant, zero when nothing requests
// Priority starts at (last_grant+1) mod THREADS; reset makes thread 0 first.
// -----------------------------------------------------------------------------
module e203_rr_arb
   import e203_exu_longp_sched_pkg::*;
#(
   parameter int THREADS = E203_THREADS_NUM
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [THREADS-1:0] req,
   input  logic               lock,
   input  logic               acc,
   output logic [THREADS-1:0] grant
);

   localparam int IW = rr_idx_w(THREADS);

   logic [IW-1:0]      last_q;
   logic [IW-1:0]      grant_idx;
   logic [THREADS-1:0] hold_q;
   logic [THREADS-1:0] pick;
   int                 idx;

   // first requester found walking from the slot after the last winner
   always_comb begin
      pick = '0;
      idx  = 0;
      for (int k = 1; k <= THREADS; k++) begin
         idx = (int'(last_q) + k) % THREADS;
         if (req[idx] && (pick == '0))
            pick[idx] = 1'b1;
      end
   end

   assign grant = lock ? hold_q : pick;

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < THREADS; i++)
         if (grant[i])
            grant_idx = IW'(i);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= IW'(THREADS - 1);
         hold_q <= '0;
      end else begin
         hold_q <= grant;
         if (acc)
            last_q <= grant_idx;
      end
   end

endmodule

// File: rtl/e203_exu_longp_sched.sv
// -----------------------------------------------------------------------------
// e203_exu_longp_sched
// Round-robin scheduler merging per-thread long-pipe write-back requests onto
// one write-back port.
//   clk, rst_n                  : clock, synchronous active-low reset
//   req_valid/req_ready         : per-thread handshake (THREADS bits)
//   req_wdat/flags/rdidx/rdfpu  : per-thread payload, thread i at slice i
//   longp_wbck_o_valid/ready    : merged write-back handshake
//   longp_wbck_o_wdat/flags/rdidx/rdfpu : selected payload
//   longp_wbck_o_thread_sel     : one-hot owner of the payload on the output
//   sched_busy                  : any request pending or output valid
// Build option E203_LONGP_SCHED_OUTREG_EN: adds a one-entry output buffer
// (latency 1, full throughput). Without it the output is combinational from
// the granted requester and a lock keeps the grant stable while stalled.
// Outputs are held idle during reset and for one cycle after release.
// -----------------------------------------------------------------------------
module e203_exu_longp_sched
   import e203_exu_longp_sched_pkg::*;
#(
   parameter int THREADS = E203_THREADS_NUM
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [THREADS-1:0]                    req_valid,
   output logic [THREADS-1:0]                    req_ready,
   input  logic [THREADS*E203_FLEN-1:0]          req_wdat,
   input  logic [THREADS*E203_FLAG_W-1:0]        req_flags,
   input  logic [THREADS*E203_RFIDX_WIDTH-1:0]   req_rdidx,
   input  logic [THREADS-1:0]                    req_rdfpu,
   output logic                                  longp_wbck_o_valid,
   input  logic                                  longp_wbck_o_ready,
   output logic [E203_FLEN-1:0]                  longp_wbck_o_wdat,
   output logic [E203_FLAG_W-1:0]                longp_wbck_o_flags,
   output logic [E203_RFIDX_WIDTH-1:0]           longp_wbck_o_rdidx,
   output logic                                  longp_wbck_o_rdfpu,
   output logic [THREADS-1:0]                    longp_wbck_o_thread_sel,
   output logic                                  sched_busy
);

   localparam int FW = E203_FLEN;
   localparam int GW = E203_FLAG_W;
   localparam int RW = E203_RFIDX_WIDTH;

   logic               en_q;
   logic               en;
   logic               lock;
   logic               acc;
   logic [THREADS-1:0] arb_grant;
   logic [THREADS-1:0] grant;
   logic [FW-1:0]      m_wdat;
   logic [GW-1:0]      m_flags;
   logic [RW-1:0]      m_rdidx;
   logic               m_rdfpu;

   // en_q is low for the first cycle after reset release
   always_ff @(posedge clk) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= 1'b1;
   end
   assign en = en_q & rst_n;

   e203_rr_arb #(.THREADS(THREADS)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .lock  (lock),
      .acc   (acc),
      .grant (arb_grant)
   );

   assign grant = en ? arb_grant : '0;
   assign acc   = |(req_valid & req_ready);

   // AND-OR mux on the one-hot grant
   always_comb begin
      m_wdat  = '0;
      m_flags = '0;
      m_rdidx = '0;
      m_rdfpu = 1'b0;
      for (int i = 0; i < THREADS; i++) begin
         if (grant[i]) begin
            m_wdat  = m_wdat  | req_wdat [i*FW +: FW];
            m_flags = m_flags | req_flags[i*GW +: GW];
            m_rdidx = m_rdidx | req_rdidx[i*RW +: RW];
            m_rdfpu = m_rdfpu | req_rdfpu[i];
         end
      end
   end

`ifdef E203_LONGP_SCHED_OUTREG_EN
   logic               buf_vld;
   logic [FW-1:0]      buf_wdat;
   logic [GW-1:0]      buf_flags;
   logic [RW-1:0]      buf_rdidx;
   logic               buf_rdfpu;
   logic [THREADS-1:0] buf_sel;

   // the buffer decouples the stall path, so no grant lock is needed
   assign lock      = 1'b0;
   assign req_ready = grant & {THREADS{~buf_vld | longp_wbck_o_ready}};

   always_ff @(posedge clk) begin
      if (!rst_n) buf_vld <= 1'b0;
      else        buf_vld <= acc | (buf_vld & ~longp_wbck_o_ready);
   end

   // payload flops carry no reset; buf_vld qualifies them
   always_ff @(posedge clk) begin
      if (acc) begin
         buf_wdat  <= m_wdat;
         buf_flags <= m_flags;
         buf_rdidx <= m_rdidx;
         buf_rdfpu <= m_rdfpu;
         buf_sel   <= grant;
      end
   end

   assign longp_wbck_o_valid      = buf_vld & en;
   assign longp_wbck_o_wdat       = buf_wdat;
   assign longp_wbck_o_flags      = buf_flags;
   assign longp_wbck_o_rdidx      = buf_rdidx;
   assign longp_wbck_o_rdfpu      = buf_rdfpu;
   assign longp_wbck_o_thread_sel = longp_wbck_o_valid ? buf_sel : '0;
`else
   logic lock_q;

   // a stalled output pins the grant so a late higher-priority request
   // cannot swap the payload under the consumer
   always_ff @(posedge clk) begin
      if (!rst_n) lock_q <= 1'b0;
      else        lock_q <= longp_wbck_o_valid & ~longp_wbck_o_ready;
   end

   assign lock                    = lock_q;
   assign req_ready               = grant & {THREADS{longp_wbck_o_ready}};
   assign longp_wbck_o_valid      = |grant;
   assign longp_wbck_o_wdat       = m_wdat;
   assign longp_wbck_o_flags      = m_flags;
   assign longp_wbck_o_rdidx      = m_rdidx;
   assign longp_wbck_o_rdfpu      = m_rdfpu;
   assign longp_wbck_o_thread_sel = grant;
`endif

   assign sched_busy = (|req_valid) | longp_wbck_o_valid;

   // requesters must not withdraw or alter a pending request
   for (genvar i = 0; i < THREADS; i++) begin : g_chk
      a_hold: assert property (@(posedge clk) disable iff (!rst_n)
         (req_valid[i] && !req_ready[i]) |=>
         (!rst_n || (req_valid[i] && $stable(req_wdat[i*FW +: FW]))));
   end

endmodule

// File: tb/tb_e203_exu_longp_sched.sv
// -----------------------------------------------------------------------------
// tb_e203_exu_longp_sched
// Directed table of {inputs, expected outputs} for THREADS=2, followed by a
// randomized run checked against a cycle-level behavioural model.
// Expectations follow E203_LONGP_SCHED_OUTREG_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_e203_exu_longp_sched;

   localparam int T = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [T-1:0]    vld = '0;
   logic            ordy = 1'b1;
   logic [31:0]     wd [T];
   logic [4:0]      fl [T];
   logic [4:0]      ri [T];
   logic            fp [T];

   logic [T-1:0]    req_ready;
   logic            o_valid;
   logic [31:0]     o_wdat;
   logic [4:0]      o_flags;
   logic [4:0]      o_rdidx;
   logic            o_rdfpu;
   logic [T-1:0]    o_sel;
   logic            busy;

   always #5 clk = ~clk;

   e203_exu_longp_sched #(.THREADS(T)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .req_valid               (vld),
      .req_ready               (req_ready),
      .req_wdat                ({wd[1], wd[0]}),
      .req_flags               ({fl[1], fl[0]}),
      .req_rdidx               ({ri[1], ri[0]}),
      .req_rdfpu               ({fp[1], fp[0]}),
      .longp_wbck_o_valid      (o_valid),
      .longp_wbck_o_ready      (ordy),
      .longp_wbck_o_wdat       (o_wdat),
      .longp_wbck_o_flags      (o_flags),
      .longp_wbck_o_rdidx      (o_rdidx),
      .longp_wbck_o_rdfpu      (o_rdfpu),
      .longp_wbck_o_thread_sel (o_sel),
      .sched_busy              (busy)
   );

   typedef struct {
      bit       rst;
      bit [1:0] v;
      bit       o;
      bit       ev;
      bit [1:0] er;
      bit [1:0] es;
      bit       eb;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // ---------------- reference model ----------------
   bit          m_en_q = 0;
   int          m_last = T - 1;
   int          m_held = -1;
   bit          b_v = 0;
   int          b_thr = 0;
   logic [31:0] b_wdat;
   logic [4:0]  b_fl, b_ri;
   logic        b_fp;
   int          win;
   bit          e_v, e_b;
   bit [1:0]    e_r, e_s;
   logic [31:0] e_wdat;
   logic [4:0]  e_fl, e_ri;
   logic        e_fp;

   task automatic model_eval();
      bit en;
      int ii;
      en  = m_en_q && rst_n;
      win = -1;
      if (en) begin
`ifndef E203_LONGP_SCHED_OUTREG_EN
         if (m_held >= 0) win = m_held;
`endif
         for (int k = 1; k <= T; k++) begin
            ii = (m_last + k) % T;
            if (vld[ii] && win < 0) win = ii;
         end
      end
`ifdef E203_LONGP_SCHED_OUTREG_EN
      e_r    = (win >= 0 && (!b_v || ordy)) ? 2'(1 << win) : 2'b00;
      e_v    = en && b_v;
      e_s    = e_v ? 2'(1 << b_thr) : 2'b00;
      e_wdat = b_wdat; e_fl = b_fl; e_ri = b_ri; e_fp = b_fp;
`else
      e_v = (win >= 0);
      e_r = (e_v && ordy) ? 2'(1 << win) : 2'b00;
      e_s = e_v ? 2'(1 << win) : 2'b00;
      if (e_v) begin
         e_wdat = wd[win]; e_fl = fl[win]; e_ri = ri[win]; e_fp = fp[win];
      end
`endif
      e_b = (vld != 0) || e_v;
   endtask

   task automatic model_upd();
      if (!rst_n) begin
         m_en_q = 0; m_last = T - 1; m_held = -1; b_v = 0;
      end else begin
         m_en_q = 1;
         if (e_r != 0) m_last = win;
`ifdef E203_LONGP_SCHED_OUTREG_EN
         if (e_r != 0) begin
            b_v = 1; b_thr = win;
            b_wdat = wd[win]; b_fl = fl[win]; b_ri = ri[win]; b_fp = fp[win];
         end else if (ordy) begin
            b_v = 0;
         end
`else
         m_held = (e_v && !ordy) ? win : -1;
`endif
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input bit use_tbl, input vec_t t);
      @(negedge clk);
      model_eval();
      if (use_tbl) begin
         chk("tbl_valid", 64'(o_valid), 64'(t.ev));
         chk("tbl_ready", 64'(req_ready), 64'(t.er));
         chk("tbl_sel", 64'(o_sel), 64'(t.es));
         chk("tbl_busy", 64'(busy), 64'(t.eb));
         if (t.ev) begin
            chk("tbl_wdat", 64'(o_wdat), (t.es == 2'b01) ? 64'h1234 : 64'hBEEF);
            chk("tbl_rdidx", 64'(o_rdidx), (t.es == 2'b01) ? 64'd5 : 64'd9);
         end
      end else begin
         chk("rnd_valid", 64'(o_valid), 64'(e_v));
         chk("rnd_ready", 64'(req_ready), 64'(e_r));
         chk("rnd_sel", 64'(o_sel), 64'(e_s));
         chk("rnd_busy", 64'(busy), 64'(e_b));
         if (e_v) begin
            chk("rnd_wdat", 64'(o_wdat), 64'(e_wdat));
            chk("rnd_flags", 64'(o_flags), 64'(e_fl));
            chk("rnd_rdidx", 64'(o_rdidx), 64'(e_ri));
            chk("rnd_rdfpu", 64'(o_rdfpu), 64'(e_fp));
         end
      end
      @(posedge clk);
      model_upd();
      #1;
   endtask

   task automatic add(input bit r, input bit [1:0] v, input bit o, input bit ev,
                      input bit [1:0] er, input bit [1:0] es, input bit eb);
      vec_t t;
      t.rst = r; t.v = v; t.o = o; t.ev = ev; t.er = er; t.es = es; t.eb = eb;
      tbl.push_back(t);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t dummy;
      wd[0] = 32'h1234; ri[0] = 5'd5; fl[0] = 5'h01; fp[0] = 1'b0;
      wd[1] = 32'hBEEF; ri[1] = 5'd9; fl[1] = 5'h1E; fp[1] = 1'b1;

      //   rst  v      o  ev  er     es     eb
`ifdef E203_LONGP_SCHED_OUTREG_EN
      add(0, 2'b00, 1, 0, 2'b00, 2'b00, 0);
      add(0, 2'b00, 1, 0, 2'b00, 2'b00, 0);
      add(1, 2'b01, 1, 0, 2'b00, 2'b00, 1);   // idle cycle after release
      add(1, 2'b01, 1, 0, 2'b01, 2'b00, 1);   // thread0 0x1234/5 accepted
      add(1, 2'b10, 1, 1, 2'b10, 2'b01, 1);   // visible next cycle, thread1 fills
      add(1, 2'b01, 0, 1, 2'b00, 2'b10, 1);   // no bubble; stall blocks ready
      add(1, 2'b01, 0, 1, 2'b00, 2'b10, 1);   // buffer holds thread1
      add(1, 2'b01, 1, 1, 2'b01, 2'b10, 1);   // drain and fill together
      add(1, 2'b00, 1, 1, 2'b00, 2'b01, 1);
      add(1, 2'b00, 1, 0, 2'b00, 2'b00, 0);   // drain only empties
      add(1, 2'b01, 0, 0, 2'b01, 2'b00, 1);
      add(1, 2'b00, 0, 1, 2'b00, 2'b01, 1);   // buffered, stalled
      add(0, 2'b11, 0, 0, 2'b00, 2'b00, 1);   // reset discards buffer
      add(1, 2'b11, 1, 0, 2'b00, 2'b00, 1);
      add(1, 2'b11, 1, 0, 2'b01, 2'b00, 1);   // thread0 first after reset
      add(1, 2'b10, 1, 1, 2'b10, 2'b01, 1);
      add(1, 2'b00, 1, 1, 2'b00, 2'b10, 1);
      add(1, 2'b00, 1, 0, 2'b00, 2'b00, 0);
`else
      add(0, 2'b11, 1, 0, 2'b00, 2'b00, 1);
      add(0, 2'b11, 1, 0, 2'b00, 2'b00, 1);
      add(1, 2'b11, 1, 0, 2'b00, 2'b00, 1);   // idle cycle after release
      add(1, 2'b11, 1, 1, 2'b01, 2'b01, 1);   // rotation 0,1,0,1
      add(1, 2'b11, 1, 1, 2'b10, 2'b10, 1);
      add(1, 2'b11, 1, 1, 2'b01, 2'b01, 1);
      add(1, 2'b11, 1, 1, 2'b10, 2'b10, 1);
      add(1, 2'b01, 1, 1, 2'b01, 2'b01, 1);
      add(1, 2'b10, 1, 1, 2'b10, 2'b10, 1);   // last grant -> thread1
      add(1, 2'b10, 0, 1, 2'b00, 2'b10, 1);   // stall
      add(1, 2'b11, 0, 1, 2'b00, 2'b10, 1);   // thread0 must not preempt
      add(1, 2'b11, 0, 1, 2'b00, 2'b10, 1);
      add(1, 2'b11, 1, 1, 2'b10, 2'b10, 1);   // thread1 accepted
      add(1, 2'b01, 1, 1, 2'b01, 2'b01, 1);   // then thread0
      add(1, 2'b10, 1, 1, 2'b10, 2'b10, 1);   // lone thread1 every cycle
      add(1, 2'b10, 1, 1, 2'b10, 2'b10, 1);
      add(1, 2'b10, 1, 1, 2'b10, 2'b10, 1);
      add(1, 2'b00, 1, 0, 2'b00, 2'b00, 0);
      add(1, 2'b11, 0, 1, 2'b00, 2'b01, 1);
      add(0, 2'b11, 0, 0, 2'b00, 2'b00, 1);   // reset mid-transfer
      add(1, 2'b11, 1, 0, 2'b00, 2'b00, 1);
      add(1, 2'b11, 1, 1, 2'b01, 2'b01, 1);   // thread0 first after reset
      add(1, 2'b10, 1, 1, 2'b10, 2'b10, 1);
`endif

      foreach (tbl[i]) begin
         rst_n = tbl[i].rst;
         vld   = tbl[i].v;
         ordy  = tbl[i].o;
         step(1'b1, tbl[i]);
      end

      // randomized run against the model
      dummy = tbl[0];
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < T; i++) begin
            if (!(vld[i] && !e_r[i])) begin
               vld[i] = ($urandom_range(0, 3) != 0);
               wd[i]  = $urandom;
               fl[i]  = 5'($urandom);
               ri[i]  = 5'($urandom);
               fp[i]  = 1'($urandom);
            end
         end
         rst_n = ($urandom_range(0, 79) != 0);
         ordy  = ($urandom_range(0, 3) != 0);
         step(1'b0, dummy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/e203_exu_longp_sched.md
E203_EXU_LONGP_SCHED -- requirements
Module: e203_exu_longp_sched

Interface
REQ-001 SHALL have parameter THREADS, default `E203_THREADS_NUM (2), number of per-thread long-pipe write-back requesters.
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  THREADS  per-thread write-back request valid.
REQ-005 SHALL have port req_ready  output  THREADS  per-thread request accepted.
REQ-006 SHALL have port req_wdat  input  THREADS*`E203_FLEN  per-thread result data, thread i at slice i.
REQ-007 SHALL have port req_flags  input  THREADS*5  per-thread FPU flags.
REQ-008 SHALL have port req_rdidx  input  THREADS*`E203_RFIDX_WIDTH  per-thread destination register index.
REQ-009 SHALL have port req_rdfpu  input  THREADS  per-thread destination is FP regfile.
REQ-010 SHALL have port longp_wbck_o_valid  output  1  arbitrated write-back valid.
REQ-011 SHALL have port longp_wbck_o_ready  input  1  final write-back stage ready.
REQ-012 SHALL have ports longp_wbck_o_wdat/flags/rdidx/rdfpu  output  FLEN/5/RFIDX_WIDTH/1  selected payload.
REQ-013 SHALL have port longp_wbck_o_thread_sel  output  THREADS  one-hot owning thread of output payload.
REQ-014 SHALL have port sched_busy  output  1  high while any request pending or output valid.

Function
REQ-015 Arbitration SHALL be round-robin among asserted req_valid bits; highest priority is thread (last_grant+1) mod THREADS.
REQ-016 Grant SHALL be one-hot or zero; no grant when no req_valid.
REQ-017 Requesters SHALL hold valid and payload stable until req_ready; block does not tolerate withdrawal (checker asserts).
REQ-018 last_grant SHALL update only on an accepted request (req_valid[i] & req_ready[i]).
REQ-019 Without output register (REQ-031): output combinational from granted requester, latency 0; req_ready[i] = grant[i] & longp_wbck_o_ready.
REQ-020 Without output register: when longp_wbck_o_valid & ~longp_wbck_o_ready, a lock flop SHALL freeze grant next cycle; a newly asserting higher-priority thread SHALL NOT preempt; lock clears on handshake.
REQ-021 With output register: one-entry buffer; req_ready[i] = grant[i] & (~buf_vld | longp_wbck_o_ready); latency 1 cycle; full throughput 1/cycle.
REQ-022 With output register: simultaneous drain and fill SHALL keep buf_vld=1 and load new payload; drain without fill clears buf_vld.
REQ-023 With output register: buffered payload and thread_sel SHALL stay stable while buf_vld & ~longp_wbck_o_ready.
REQ-024 longp_wbck_o_thread_sel SHALL equal the one-hot thread of the payload currently on output; zero when output invalid.
REQ-025 THREADS=1 SHALL degenerate to pass-through (or single buffer), grant bit 0 whenever req_valid[0].
REQ-026 sched_busy = |req_valid | longp_wbck_o_valid.

Reset
REQ-027 On rst_n=0 at a clock edge: last_grant SHALL become THREADS-1 (thread 0 first priority), lock=0, buf_vld=0.
REQ-028 During and one cycle after reset: longp_wbck_o_valid=0, req_ready=0, thread_sel=0, sched_busy follows req_valid.
REQ-029 Reset mid-transfer SHALL discard buffered payload without handshake; no partial state survives.
REQ-030 Payload flops need no reset; only control flops are reset.

Configuration
REQ-031 Macro E203_LONGP_SCHED_OUTREG_EN defined: output register per REQ-021..023; undefined: combinational path per REQ-019..020, no buffer flops.

Structure
REQ-032 Widths (FLEN, RFIDX_WIDTH, THREADS_NUM) SHALL come from e203_defines.v; no new shared package entries except a one-hot round-robin helper constant set if needed.
REQ-033 One sub-module natural: e203_rr_arb (THREADS-wide round-robin with lock input, one-hot grant out).

Verification
REQ-034 THREADS=2, no OUTREG: req_valid=2'b11, o_ready=1 for 4 cycles -> grants 0,1,0,1; thread_sel 01,10,01,10.
REQ-035 No OUTREG: thread1 valid, o_ready=0 for 3 cycles, thread0 asserts cycle 2 -> grant stays thread1, payload stable; o_ready=1 -> thread1 accepted, thread0 granted next.
REQ-036 OUTREG: thread0 wdat=0x1234 rdidx=5 valid cycle 0, o_ready=1 -> output valid cycle 1 with 0x1234/5, thread_sel=01.
REQ-037 OUTREG: back-to-back thread0 then thread1, o_ready=1 -> output valid cycles 1,2 with no bubble; o_ready=0 at cycle 2 -> req_ready=0, buffer holds thread1 payload.
REQ-038 rst_n=0 while buf_vld=1 -> next cycle o_valid=0; after release with 2'b11 valid, thread 0 granted first.
REQ-039 Only thread1 valid continuously, o_ready=1 -> thread1 accepted every cycle (no idle rotation bubbles).
